// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer states and the default operand width.
package arith_pkg;

  localparam int unsigned ARITH_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock through a single full-subtractor cell,
// ready/valid on both sides, with borrow/overflow/zero flags on the registered result.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_W
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, d_q;
  logic [CntW-1:0]  cnt_q;
  logic             brw_q, a_msb_q, b_msb_q;
  logic             bout_q, ovf_q, zero_q;

  logic             fs_d, fs_bout;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at d[0].
  assign d_next = {fs_d, d_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            d_q     <= '0;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          brw_q  <= fs_bout;
          d_q    <= d_next;
          cnt_q  <= cnt_q + 1'b1;
          // Flags are resolved on the last shift so they appear together with d.
          if (cnt_q == CntW'(WIDTH - 1)) begin
            bout_q  <= fs_bout;
            zero_q  <= (d_next == '0);
            ovf_q   <= (a_msb_q != b_msb_q) && (d_next[WIDTH-1] != a_msb_q);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus handshake/reset corner sequences.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands for one accepting edge, then drops in_valid.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int guard = 0;
    while (!bus.in_ready && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) check("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid is seen (bounded).
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    check({tag, " latency"}, lat, W);
    check({tag, " d"}, bus.d, v.d);
    check({tag, " bout"}, bus.bout, v.bout);
    check({tag, " ovf"}, bus.ovf, v.ovf);
    check({tag, " zero"}, bus.zero, v.zero);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   lat;
    logic [W-1:0] held_d;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bout: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bout: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bout: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, bin: 1'b0, d: 8'h00, bout: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[7] = '{a: 8'h80, b: 8'h7F, bin: 1'b0, d: 8'h01, bout: 1'b0, ovf: 1'b1, zero: 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset d", bus.d, 8'h00);
    check("reset bout", bus.bout, 1'b0);
    check("reset ovf", bus.ovf, 1'b0);
    check("reset zero", bus.zero, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done(0, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      handshake($sformatf("vec%0d", i));
    end

    // In-flight in_valid pulse must be ignored.
    start_op(8'h10, 8'h0F, 1'b1);
    tick();
    tick();
    check("busy in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    bus.bin      = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_done(3, lat);
    check_result("ignore", vecs[4], lat);

    // Back-pressure: result held in DONE while out_ready is low.
    held_d = bus.d;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d out_valid", k), bus.out_valid, 1'b1);
      check($sformatf("stall%0d in_ready", k), bus.in_ready, 1'b0);
      check($sformatf("stall%0d d", k), bus.d, held_d);
      check($sformatf("stall%0d zero", k), bus.zero, 1'b1);
    end

    // out_ready and in_valid together: handshake only, accept on the next edge.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h5A;
    bus.b         = 8'h3C;
    bus.bin       = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    check("coincide in_ready", bus.in_ready, 1'b1);
    check("coincide out_valid", bus.out_valid, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("coincide accepted", bus.in_ready, 1'b0);
    wait_done(0, lat);
    check_result("coincide", vecs[0], lat);
    handshake("coincide");

    // Reset during the 4th shift cycle aborts the operation.
    start_op(8'h80, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort in_ready", bus.in_ready, 1'b1);
    check("abort out_valid", bus.out_valid, 1'b0);
    check("abort d", bus.d, 8'h00);
    v = vecs[0];
    start_op(v.a, v.b, v.bin);
    wait_done(0, lat);
    check_result("post_abort", v, lat);
    handshake("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
